// File: rtl/pp_accumulator_pkg.sv
// Shared definitions for the partial-product accumulator.
// Holds the FSM state encoding and the beat index width.
package pp_accumulator_pkg;

   localparam int unsigned PP_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/pp_accumulator.sv
// Accumulates pre-shifted partial products into one multiply result.
// Optional sticky carry-out flag is enabled by defining PP_ACCUMULATOR_OVF_EN.
module pp_accumulator
   import pp_accumulator_pkg::*;
#(
   parameter int unsigned N_PP  = 4,
   parameter int unsigned ACC_W = 32
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                start,
   input  logic                pp_valid,
   output logic                pp_ready,
   input  logic [ACC_W-1:0]    pp_data,
   input  logic [PP_IDX_W-1:0] pp_index,
   input  logic                pp_last,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [ACC_W-1:0]    res,
   output logic                idx_err,
   output logic                ovf
);

   localparam logic [PP_IDX_W-1:0] LAST_CNT = PP_IDX_W'(N_PP - 1);

   state_e                state_q, state_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [PP_IDX_W-1:0]   cnt_q, cnt_d;
   logic                  idx_err_q, idx_err_d;
   logic                  xfer;
   logic                  clear;
   logic [ACC_W-1:0]      sum;

`ifdef PP_ACCUMULATOR_OVF_EN
   logic [ACC_W:0]        sum_full;
   logic                  ovf_q;

   assign sum_full = {1'b0, acc_q} + {1'b0, pp_data};
   assign sum      = sum_full[ACC_W-1:0];
`else
   assign sum      = acc_q + pp_data;
`endif

   // A start in ACCUM aborts, so the beat presented that cycle is refused.
   assign pp_ready  = (state_q == ACCUM) && !start;
   assign xfer      = pp_valid && pp_ready;
   assign clear     = start && ((state_q == IDLE) || (state_q == ACCUM));
   assign res_valid = (state_q == DONE);
   assign res       = (state_q == DONE) ? acc_q : '0;
   assign idx_err   = idx_err_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      idx_err_d = idx_err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d     = '0;
               cnt_d     = '0;
               idx_err_d = 1'b0;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (start) begin
               acc_d     = '0;
               cnt_d     = '0;
               idx_err_d = 1'b0;
            end else if (xfer) begin
               acc_d = sum;
               cnt_d = cnt_q + 1'b1;
               if (pp_index != cnt_q) begin
                  idx_err_d = 1'b1;
               end
               if ((cnt_q == LAST_CNT) || pp_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         idx_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         idx_err_q <= idx_err_d;
      end
   end

`ifdef PP_ACCUMULATOR_OVF_EN
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ovf_q <= 1'b0;
      end else if (clear) begin
         ovf_q <= 1'b0;
      end else if (xfer && sum_full[ACC_W]) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pp_accumulator.sv
// Randomized self-checking bench for pp_accumulator against a sum-of-beats model.
module tb_pp_accumulator;

   localparam int unsigned N_PP  = 4;
   localparam int unsigned ACC_W = 32;

   logic              CLK = 1'b0;
   logic              RSTn;
   logic              start;
   logic              pp_valid;
   logic              pp_ready;
   logic [ACC_W-1:0]  pp_data;
   logic [3:0]        pp_index;
   logic              pp_last;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res;
   logic              idx_err;
   logic              ovf;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] bd [16];
   logic [3:0]  bi [16];
   logic        bl [16];

   pp_accumulator #(
      .N_PP  (N_PP),
      .ACC_W (ACC_W)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .start     (start),
      .pp_valid  (pp_valid),
      .pp_ready  (pp_ready),
      .pp_data   (pp_data),
      .pp_index  (pp_index),
      .pp_last   (pp_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res       (res),
      .idx_err   (idx_err),
      .ovf       (ovf)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_beats(input logic [31:0] d0, d1, d2, d3,
                            input logic [3:0] i0, i1, i2, i3,
                            input logic l0, l1, l2, l3);
      bd[0] = d0; bd[1] = d1; bd[2] = d2; bd[3] = d3;
      bi[0] = i0; bi[1] = i1; bi[2] = i2; bi[3] = i3;
      bl[0] = l0; bl[1] = l1; bl[2] = l2; bl[3] = l3;
   endtask

   // Model: result is the modular sum of beats up to the first pp_last or the N_PP-th beat.
   task automatic do_mult(input string tag, input bit do_start, input int gmax,
                          input int rrd, input bit poke);
      logic [32:0] s33;
      logic [31:0] esum;
      logic        eerr;
      logic        eovf;
      logic        eovf_seen;
      int          t;
      esum = '0; eerr = 1'b0; eovf_seen = 1'b0; t = 0;
      for (int k = 0; k < int'(N_PP); k++) begin
         t = k + 1;
         s33 = {1'b0, esum} + {1'b0, bd[k]};
         if (s33[32]) eovf_seen = 1'b1;
         esum = s33[31:0];
         if (int'(bi[k]) != k) eerr = 1'b1;
         if (bl[k]) break;
      end
`ifdef PP_ACCUMULATOR_OVF_EN
      eovf = eovf_seen;
`else
      eovf = 1'b0;
`endif
      if (do_start) begin
         start = 1'b1;
         @(negedge CLK);
         check({tag, " idle_start_ready"}, 64'(pp_ready), 64'd0);
         step();
         start = 1'b0;
      end
      for (int k = 0; k < t; k++) begin
         pp_valid = 1'b0;
         repeat ($urandom_range(0, gmax)) step();
         pp_valid = 1'b1;
         pp_data  = bd[k];
         pp_index = bi[k];
         pp_last  = bl[k];
         @(negedge CLK);
         check({tag, " beat_ready"}, 64'(pp_ready), 64'd1);
         step();
         pp_valid = 1'b0;
         pp_last  = 1'b0;
      end
      @(negedge CLK);
      check({tag, " res_valid"}, 64'(res_valid), 64'd1);
      check({tag, " res"}, 64'(res), 64'(esum));
      check({tag, " idx_err"}, 64'(idx_err), 64'(eerr));
      check({tag, " ovf"}, 64'(ovf), 64'(eovf));
      if (poke) begin
         start = 1'b1;
         step();
         start = 1'b0;
         @(negedge CLK);
         check({tag, " done_start_ignored"}, 64'(res_valid), 64'd1);
         check({tag, " done_start_res"}, 64'(res), 64'(esum));
      end
      for (int r = 0; r < rrd; r++) begin
         step();
         @(negedge CLK);
         check({tag, " hold_valid"}, 64'(res_valid), 64'd1);
         check({tag, " hold_res"}, 64'(res), 64'(esum));
      end
      res_ready = 1'b1;
      if (poke) start = 1'b1;
      step();
      res_ready = 1'b0;
      start     = 1'b0;
      @(negedge CLK);
      check({tag, " consumed_valid"}, 64'(res_valid), 64'd0);
      check({tag, " consumed_res"}, 64'(res), 64'd0);
      if (poke) begin
         check({tag, " idle_after_consume"}, 64'(pp_ready), 64'd0);
         step();
         @(negedge CLK);
         check({tag, " still_idle"}, 64'(pp_ready), 64'd0);
         check({tag, " no_second_valid"}, 64'(res_valid), 64'd0);
      end
   endtask

   initial begin
      RSTn = 1'b0; start = 1'b0; pp_valid = 1'b0; pp_data = '0;
      pp_index = '0; pp_last = 1'b0; res_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst pp_ready", 64'(pp_ready), 64'd0);
      check("rst res_valid", 64'(res_valid), 64'd0);
      check("rst res", 64'(res), 64'd0);
      check("rst idx_err", 64'(idx_err), 64'd0);
      check("rst ovf", 64'(ovf), 64'd0);
      RSTn = 1'b1;
      step();

      set_beats(8, 0, 0, 64, 0, 1, 2, 3, 0, 0, 0, 0);
      do_mult("mul8x9", 1'b1, 0, 0, 1'b0);
      do_mult("backpressure", 1'b1, 3, 5, 1'b0);
      set_beats(5, 10, 99, 99, 0, 1, 2, 3, 0, 1, 0, 0);
      do_mult("early_end", 1'b1, 1, 1, 1'b0);
      set_beats(1, 2, 4, 8, 0, 2, 2, 3, 0, 0, 0, 0);
      do_mult("idx_err", 1'b1, 0, 2, 1'b0);
      set_beats(32'hFFFF_FFFF, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
      do_mult("carry", 1'b1, 0, 0, 1'b0);
      set_beats(7, 11, 13, 17, 0, 1, 2, 3, 0, 0, 0, 0);
      do_mult("done_start", 1'b1, 0, 2, 1'b1);

      // Abort: two beats, then restart with a beat presented in the same cycle.
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         pp_valid = 1'b1; pp_data = 32'd100; pp_index = 4'(k + 1);
         step();
      end
      start = 1'b1; pp_valid = 1'b1; pp_data = 32'd1000; pp_index = 4'd0;
      @(negedge CLK);
      check("abort ready", 64'(pp_ready), 64'd0);
      step();
      start = 1'b0; pp_valid = 1'b0;
      set_beats(3, 6, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
      do_mult("abort_3x3", 1'b0, 1, 1, 1'b0);

      // Asynchronous reset mid-ACCUM after an index error.
      start = 1'b1; step(); start = 1'b0;
      pp_valid = 1'b1; pp_data = 32'd5; pp_index = 4'd3; step();
      pp_valid = 1'b0;
      #2 RSTn = 1'b0;
      #1;
      check("arst pp_ready", 64'(pp_ready), 64'd0);
      check("arst res_valid", 64'(res_valid), 64'd0);
      check("arst res", 64'(res), 64'd0);
      check("arst idx_err", 64'(idx_err), 64'd0);
      check("arst ovf", 64'(ovf), 64'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      for (int r = 0; r < 3; r++) begin
         step();
         @(negedge CLK);
         check("post_rst res_valid", 64'(res_valid), 64'd0);
         check("post_rst pp_ready", 64'(pp_ready), 64'd0);
      end

      for (int m = 0; m < 40; m++) begin
         for (int k = 0; k < 16; k++) begin
            bd[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            bi[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(k);
            bl[k] = ($urandom_range(0, 4) == 0);
         end
         do_mult("random", 1'b1, 2, $urandom_range(0, 3), 1'($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
